alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
Initiator side of the fourbit ALU operand/opcode interface. Accepts ALU commands {a, b, opcode} over a valid/ready stream and buffers them in a small FIFO. Issues one command at a time on the registered ALU drive port, captures the combinational ALU result, and returns it on a valid/ready response stream. Sits between the test/command source and the ALU instance; the ALU itself stays purely combinational.

Parameters:
N, 8, ALU result width; must match the ALU instance N.
DEPTH, 4, command FIFO entries; power of 2, ≥2.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  command FIFO can accept.
cmd_a  input  4  operand a.
cmd_b  input  4  operand b.
cmd_op  input  alu_opcode_t  operation (alu_pkg enum).
alu_a  output  4  registered operand a to ALU.
alu_b  output  4  registered operand b to ALU.
alu_opcode  output  alu_opcode_t  registered opcode to ALU.
alu_result  input  N  combinational ALU result.
rsp_valid  output  1  response present.
rsp_ready  input  1  response consumer ready.
rsp_data  output  N  captured ALU result.
rsp_op  output  alu_opcode_t  opcode that produced rsp_data.
rsp_err  output  1  opcode was not ADD/SUB/MUL/AND/DEC.
busy  output  1  FIFO non-empty or FSM not IDLE.
rsp_count  output  8  completed response handshakes, wraps 255→0.

Behaviour:
- Reset (async, immediate): FIFO pointers/count cleared, state IDLE, rsp_valid=0, rsp_data=0, rsp_op=ADD, rsp_err=0, alu_a=0, alu_b=0, alu_opcode=ADD, rsp_count=0, busy=0. cmd_ready=0 while rst high. In-flight and buffered commands are dropped. No partial response after reset release.
- FIFO: push when cmd_valid && cmd_ready. cmd_ready = !full && !rst. No pass-through when full: a same-cycle pop does not free space for a same-cycle push. Pointers wrap modulo DEPTH.
- FSM states IDLE, DRIVE, RESP:
  IDLE: if FIFO non-empty → pop head into alu_a/alu_b/alu_opcode, go to DRIVE. Otherwise hold; alu_* hold their last values.
  DRIVE: exactly one cycle. At its closing edge: rsp_data←alu_result, rsp_op←alu_opcode, rsp_err←(alu_opcode not a defined enum value), rsp_valid←1; go to RESP.
  RESP: rsp_valid=1; rsp_data/rsp_op/rsp_err stable until the handshake. On rsp_valid && rsp_ready: rsp_valid←0 and rsp_count+1. Same edge: if FIFO non-empty, pop and load alu_* and go to DRIVE; else go to IDLE.
- Latency: command pushed at edge k into an empty, IDLE block → alu_* loaded at edge k+1 → rsp_valid high after edge k+2.
- Throughput: one response per 2 cycles with rsp_ready held high.
- alu_* change only on a pop edge or reset. They are stable for the whole DRIVE cycle.
- Width rule: rsp_data is alu_result verbatim (N bits). No extension or truncation.
- Invalid opcode: forwarded to the ALU unchanged. The response carries the ALU default output (0) with rsp_err=1. Not dropped.
- rsp_ready is ignored outside RESP. cmd_valid is ignored when cmd_ready=0. Commands are never lost or reordered.
- busy = (state != IDLE) || FIFO non-empty.

Test Plan:
- Single ADD a=3, b=5, rsp_ready=1 → rsp_valid 2 cycles after accept; rsp_data=8'h08, rsp_op=ADD, rsp_err=0, rsp_count=1.
- Back-to-back, rsp_ready=1: MUL 15×15, SUB 2−7, AND 4'hC&4'hA, ADD 15+15 → responses in order 8'hE1, 8'hFB, 8'h08, 8'h1E. Responses spaced 2 cycles apart; rsp_count=4; busy falls after the last one.
- Backpressure/full, rsp_ready=0, push commands every cycle → exactly 5 accepted (1 held in RESP, 4 in FIFO); cmd_ready=0 from then on. 6th command stalls; rsp_data stable. Release rsp_ready → all 6 delivered in order.
- Invalid opcode: cmd_op cast to an unused encoding, a=9, b=1 → rsp_data=0, rsp_err=1. The following ADD 1+1 returns 8'h02 with rsp_err=0.
- Reset mid-operation: 3 commands queued, assert rst during DRIVE → outputs at reset values immediately, no rsp_valid afterward. After release, a new ADD 1+2 returns 8'h03 with rsp_count=1.
- Simultaneous push and pop at full: FIFO full and response handshake in the same cycle with cmd_valid=1 → push rejected that cycle; accepted the next cycle.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the four-bit ALU: buffers {a, b, opcode} commands,
// drives them one at a time onto registered ALU inputs and returns the results.

package alu_pkg;
  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    MUL = 3'd2,
    AND = 3'd3,
    DEC = 3'd4
  } alu_opcode_t;
endpackage

module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [3:0]   cmd_a,
  input  logic [3:0]   cmd_b,
  input  alu_opcode_t  cmd_op,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output alu_opcode_t  alu_opcode,
  input  logic [N-1:0] alu_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output alu_opcode_t  rsp_op,
  output logic         rsp_err,
  output logic         busy,
  output logic [7:0]   rsp_count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [3:0]  a;
    logic [3:0]  b;
    alu_opcode_t op;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          capture;
  logic          fire;
  state_t        state;
  state_t        state_next;

  function automatic logic op_defined(input alu_opcode_t op);
    case (op)
      ADD, SUB, MUL, AND, DEC: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

  // Full is judged on the registered count, so a pop never makes room for a same-cycle push.
  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, op: cmd_op};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    capture    = 1'b0;
    fire       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        capture    = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          fire = 1'b1;
          if (!empty) begin
            pop        = 1'b1;
            state_next = DRIVE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Undefined opcodes still go to the ALU; the response just gets flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= ADD;
      rsp_data   <= '0;
      rsp_op     <= ADD;
      rsp_err    <= 1'b0;
      rsp_count  <= '0;
    end else begin
      if (pop) begin
        alu_a      <= mem[rd_ptr].a;
        alu_b      <= mem[rd_ptr].b;
        alu_opcode <= mem[rd_ptr].op;
      end
      if (capture) begin
        rsp_data <= alu_result;
        rsp_op   <= alu_opcode;
        rsp_err  <= !op_defined(alu_opcode);
      end
      if (fire) rsp_count <= rsp_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a table of single commands with hand-computed
// results, then back-to-back, backpressure/full, and mid-operation reset sequences.

module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_a;
  logic [3:0]  cmd_b;
  alu_opcode_t cmd_op;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  alu_opcode_t alu_opcode;
  logic [N-1:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [N-1:0] rsp_data;
  alu_opcode_t rsp_op;
  logic        rsp_err;
  logic        busy;
  logic [7:0]  rsp_count;

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    alu_opcode_t op;
    logic [7:0]  exp_data;
    logic        exp_err;
    string       name;
  } vec_t;

  typedef struct {
    logic [7:0]  d;
    alu_opcode_t op;
    logic        err;
  } exp_t;

  int   num_checks = 0;
  int   num_fail   = 0;
  int   cycle      = 0;
  int   hs_total   = 0;
  exp_t exp_q[$];
  int   hs_cyc[$];
  vec_t vecs[8];
  vec_t bp[6];

  alu_cmd_sequencer #(.N(N), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_err(rsp_err),
    .busy(busy), .rsp_count(rsp_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Stand-in for the combinational four-bit ALU; undefined opcodes give 0.
  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      ADD:     alu_result = {4'b0, alu_a} + {4'b0, alu_b};
      SUB:     alu_result = {4'b0, alu_a} - {4'b0, alu_b};
      MUL:     alu_result = {4'b0, alu_a} * {4'b0, alu_b};
      AND:     alu_result = {4'b0, alu_a & alu_b};
      DEC:     alu_result = {4'b0, alu_a} - 8'd1;
      default: alu_result = '0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] a, input logic [3:0] b,
                              input alu_opcode_t op, input logic [7:0] d,
                              input logic e, input string n);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.exp_data = d; v.exp_err = e; v.name = n;
    return v;
  endfunction

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.d = v.exp_data; e.op = v.op; e.err = v.exp_err;
    exp_q.push_back(e);
  endtask

  // Every response handshake is checked in order against the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      hs_total++;
      hs_cyc.push_back(cycle);
      if (exp_q.size() == 0) begin
        num_checks++;
        num_fail++;
        $display("[TB] FAIL sb_extra: got response %0h, expected none", rsp_data);
      end else begin
        e = exp_q.pop_front();
        checkOutput("sb_data", rsp_data, e.d);
        checkOutput("sb_op", rsp_op, e.op);
        checkOutput("sb_err", rsp_err, e.err);
      end
    end
  end

  // One command into an idle block with rsp_ready high, checking cycle-exact latency.
  task automatic applyStimulus(input vec_t v);
    push_exp(v);
    checkOutput({v.name, "_cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_a = v.a; cmd_b = v.b; cmd_op = v.op;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checkOutput({v.name, "_valid_k"}, rsp_valid, 0);
    @(posedge clk); #1;
    checkOutput({v.name, "_alu_a"}, alu_a, v.a);
    checkOutput({v.name, "_alu_b"}, alu_b, v.b);
    checkOutput({v.name, "_alu_op"}, alu_opcode, v.op);
    checkOutput({v.name, "_valid_k1"}, rsp_valid, 0);
    @(posedge clk); #1;
    checkOutput({v.name, "_valid_k2"}, rsp_valid, 1);
    checkOutput({v.name, "_data"}, rsp_data, v.exp_data);
    checkOutput({v.name, "_op"}, rsp_op, v.op);
    checkOutput({v.name, "_err"}, rsp_err, v.exp_err);
    @(posedge clk); #1;
    checkOutput({v.name, "_valid_done"}, rsp_valid, 0);
    checkOutput({v.name, "_count"}, rsp_count, 8'(hs_total));
    checkOutput({v.name, "_busy"}, busy, 0);
  endtask

  task automatic wait_hs(input int target, input int budget, input string name);
    int t = 0;
    while (hs_total < target && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    checkOutput({name, "_done"}, 32'(hs_total >= target), 1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int acc;
    logic rdy;

    vecs[0] = mk(4'd3,  4'd5,  ADD, 8'h08, 1'b0, "add_3_5");
    vecs[1] = mk(4'd15, 4'd15, MUL, 8'hE1, 1'b0, "mul_f_f");
    vecs[2] = mk(4'd2,  4'd7,  SUB, 8'hFB, 1'b0, "sub_2_7");
    vecs[3] = mk(4'hC,  4'hA,  AND, 8'h08, 1'b0, "and_c_a");
    vecs[4] = mk(4'd15, 4'd15, ADD, 8'h1E, 1'b0, "add_f_f");
    vecs[5] = mk(4'd0,  4'd0,  DEC, 8'hFF, 1'b0, "dec_0");
    vecs[6] = mk(4'd9,  4'd1,  alu_opcode_t'(3'd6), 8'h00, 1'b1, "bad_op");
    vecs[7] = mk(4'd1,  4'd1,  ADD, 8'h02, 1'b0, "add_after_bad");

    bp[0] = mk(4'd1,  4'd2,  ADD, 8'h03, 1'b0, "bp0");
    bp[1] = mk(4'd9,  4'd4,  SUB, 8'h05, 1'b0, "bp1");
    bp[2] = mk(4'd3,  4'd4,  MUL, 8'h0C, 1'b0, "bp2");
    bp[3] = mk(4'hF,  4'h3,  AND, 8'h03, 1'b0, "bp3");
    bp[4] = mk(4'd5,  4'd0,  DEC, 8'h04, 1'b0, "bp4");
    bp[5] = mk(4'd7,  4'd8,  ADD, 8'h0F, 1'b0, "bp5");

    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = ADD; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_rsp_op", rsp_op, ADD);
    checkOutput("rst_rsp_err", rsp_err, 0);
    checkOutput("rst_alu_a", alu_a, 0);
    checkOutput("rst_alu_b", alu_b, 0);
    checkOutput("rst_alu_op", alu_opcode, ADD);
    checkOutput("rst_count", rsp_count, 0);
    checkOutput("rst_busy", busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Back-to-back: four commands on consecutive cycles, responses every other cycle.
    base = hs_total;
    for (int i = 1; i <= 4; i++) begin
      checkOutput("b2b_cmd_ready", cmd_ready, 1);
      push_exp(vecs[i]);
      cmd_valid = 1'b1; cmd_a = vecs[i].a; cmd_b = vecs[i].b; cmd_op = vecs[i].op;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    wait_hs(base + 4, 30, "b2b");
    for (int i = 1; i < 4; i++) begin
      if (base + i < hs_cyc.size())
        checkOutput("b2b_spacing", hs_cyc[base+i] - hs_cyc[base+i-1], 2);
    end
    checkOutput("b2b_busy", busy, 0);
    checkOutput("b2b_count", rsp_count, 8'(hs_total));

    // Backpressure until full, then a handshake coinciding with a push at full.
    base = hs_total;
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      rdy = cmd_ready;
      if (acc < 6) begin
        cmd_valid = 1'b1; cmd_a = bp[acc].a; cmd_b = bp[acc].b; cmd_op = bp[acc].op;
      end else begin
        cmd_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (rdy && acc < 6) begin
        push_exp(bp[acc]);
        acc++;
      end
    end
    checkOutput("bp_accepted", acc, 5);
    checkOutput("bp_cmd_ready", cmd_ready, 0);
    checkOutput("bp_rsp_valid", rsp_valid, 1);
    checkOutput("bp_rsp_data", rsp_data, 8'h03);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("bp_data_stable", rsp_data, 8'h03);
    checkOutput("bp_still_full", cmd_ready, 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("full_pushpop_reject", cmd_ready, 1);
    rdy = cmd_ready;
    @(posedge clk); #1;
    if (rdy && acc < 6) begin
      push_exp(bp[acc]);
      acc++;
    end
    cmd_valid = 1'b0;
    checkOutput("bp_sixth_accepted", acc, 6);
    wait_hs(base + 6, 40, "bp");
    checkOutput("bp_busy", busy, 0);
    checkOutput("bp_count", rsp_count, 8'(hs_total));

    // Reset while a command sits in DRIVE with more queued behind it.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_exp(bp[i]);
      cmd_valid = 1'b1; cmd_a = bp[i].a; cmd_b = bp[i].b; cmd_op = bp[i].op;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("pre_rst_drive_valid", rsp_valid, 0);
    checkOutput("pre_rst_drive_busy", busy, 1);
    rst = 1'b1;
    #1;
    exp_q.delete();
    hs_total = 0;
    checkOutput("mid_rst_valid", rsp_valid, 0);
    checkOutput("mid_rst_data", rsp_data, 0);
    checkOutput("mid_rst_op", rsp_op, ADD);
    checkOutput("mid_rst_alu_a", alu_a, 0);
    checkOutput("mid_rst_alu_op", alu_opcode, ADD);
    checkOutput("mid_rst_count", rsp_count, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_cmd_ready", cmd_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput("post_rst_no_rsp", rsp_valid, 0);
      checkOutput("post_rst_idle", busy, 0);
    end
    applyStimulus(mk(4'd1, 4'd2, ADD, 8'h03, 1'b0, "post_rst_add"));
    checkOutput("post_rst_count1", rsp_count, 1);
    checkOutput("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fail);
    $finish;
  end

endmodule
